decode_hazard_ctrl: RTL and testbench
=====================================

DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- rs_sel  in  3  first source register (instr[10:8] field).
- rs_used  in  1  instruction reads rs_sel.
- rt_sel  in  3  second source register (instr[7:5] field).
- rt_used  in  1  instruction reads rt_sel.
- rd_sel  in  3  destination register after RegDst selection.
- rd_wr  in  1  instruction writes rd_sel.
- flush  in  1  squash the decode-stage instruction this cycle.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_sel  in  3  register written by writeback.
- stall  out  1  hold fetch/decode; combinational.
- issue  out  1  decode instruction advances; combinational.
- busy  out  8  per-register pending-write flag; bit n = R(n).
- stall_cnt  out  8  saturating count of stalled cycles.
- sb_err  out  1  sticky scoreboard underflow error.

Function
REQ-003 The block SHALL keep one 2-bit pending-write counter pc[n] for each of the 8 registers.
REQ-004 busy[n] SHALL equal (pc[n] != 0).
REQ-005 The per-source hazard SHALL be computed as: haz_rs = rs_used & (pc[rs_sel] != 0), minus the WB release of REQ-014; haz_rt is computed the same way.
REQ-006 The WAW limit SHALL be computed as: haz_rd = rd_wr & (pc[rd_sel] == 3) & ~(wb_valid & wb_sel == rd_sel).
REQ-007 stall SHALL equal id_valid & ~flush & (haz_rs | haz_rt | haz_rd).
REQ-008 issue SHALL equal id_valid & ~flush & ~stall.
REQ-009 On a rising clk edge with issue & rd_wr, pc[rd_sel] SHALL increment by 1.
REQ-010 On a rising clk edge with wb_valid, pc[wb_sel] SHALL decrement by 1.
REQ-011 When issue & rd_wr and wb_valid target the same register in one cycle, pc for that register SHALL remain unchanged.
REQ-012 A decrement with pc[wb_sel] == 0 SHALL leave the counter at 0 and set sb_err to 1; sb_err SHALL remain 1 until reset.
REQ-013 Increments SHALL never wrap from 3 to 0; the haz_rd term of REQ-006 guarantees this.
REQ-014 Writeback release (FORWARD_WB_EN only): haz_rs SHALL be suppressed when wb_valid & wb_sel == rs_sel & pc[rs_sel] == 1; haz_rt is suppressed the same way.
REQ-015 stall_cnt SHALL increment by 1 on each clock edge where stall = 1 and SHALL saturate at 255.
REQ-016 flush SHALL prevent allocation and stall assertion for that cycle; pending counters SHALL still decrement on wb_valid.
REQ-017 Latency: a register write issued in cycle N SHALL show busy = 1 from cycle N+1.

Reset
REQ-018 While rst = 0, all pc[n] SHALL be 0, busy SHALL be 8'h00, stall_cnt SHALL be 8'h00 and sb_err SHALL be 0.
REQ-019 stall and issue SHALL follow REQ-007 and REQ-008 from the reset-cleared state.
REQ-020 Reset asserted mid-operation SHALL discard all pending writes immediately, without waiting for a clock edge.

Configuration
REQ-021 The macro FORWARD_WB_EN, when defined, SHALL enable the writeback release of REQ-014; this models register-file write-before-read bypass.
REQ-022 When FORWARD_WB_EN is undefined, a source hazard SHALL persist until the counter reads 0; the pending counter is then already cleared on the cycle after writeback.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset: rst=0 mid-stream with pc[3] = 2 -> busy = 00, stall_cnt = 0, sb_err = 0 asynchronously.
- RAW stall: issue rd_sel = 2, rd_wr = 1, then next instruction rs_sel = 2, rs_used = 1 -> stall = 1, busy = 8'h04; on wb_valid with wb_sel = 2:
  - with FORWARD_WB_EN: stall = 0 in the same cycle;
  - without it: stall = 0 on the next cycle.
- WAW limit: three issues to rd = 5 with no writeback -> pc[5] = 3; fourth instruction writing R5 -> stall = 1; wb_valid with wb_sel = 5 in the same cycle -> issue = 1 and pc[5] stays 3.
- Simultaneous: issue rd = 1 and wb_sel = 1 in the same cycle with pc[1] = 1 -> pc[1] = 1 next cycle, busy[1] = 1.
- Flush: id_valid = 1, flush = 1, rs hazard present -> stall = 0, issue = 0, no counter change.
- Error/saturation:
  - wb_valid with wb_sel = 7 while pc[7] = 0 -> sb_err = 1 persists and pc[7] = 0;
  - 300 consecutive stall cycles -> stall_cnt = 255.

Source files
------------

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage register scoreboard: per-register pending-write counters drive RAW/WAW stall and issue.
// Optional macro FORWARD_WB_EN lets a same-cycle writeback release the last pending write to a source.
module decode_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] rs_sel,
    input  logic       rs_used,
    input  logic [2:0] rt_sel,
    input  logic       rt_used,
    input  logic [2:0] rd_sel,
    input  logic       rd_wr,
    input  logic       flush,
    input  logic       wb_valid,
    input  logic [2:0] wb_sel,
    output logic       stall,
    output logic       issue,
    output logic [7:0] busy,
    output logic [7:0] stall_cnt,
    output logic       sb_err
);

    logic [1:0] pc_q [8];
    logic [1:0] pc_d [8];
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic       sb_err_q, sb_err_d;

    logic       haz_rs, haz_rt, haz_rd;
    logic       wb_hit_rd;
    logic [7:0] inc_vec, dec_vec;

    assign wb_hit_rd = wb_valid && (wb_sel == rd_sel);

`ifdef FORWARD_WB_EN
    // The retiring write reaches the register file before the read, so the last pending write no longer blocks.
    assign haz_rs = rs_used && (pc_q[rs_sel] != 2'd0)
                    && !(wb_valid && (wb_sel == rs_sel) && (pc_q[rs_sel] == 2'd1));
    assign haz_rt = rt_used && (pc_q[rt_sel] != 2'd0)
                    && !(wb_valid && (wb_sel == rt_sel) && (pc_q[rt_sel] == 2'd1));
`else
    assign haz_rs = rs_used && (pc_q[rs_sel] != 2'd0);
    assign haz_rt = rt_used && (pc_q[rt_sel] != 2'd0);
`endif

    // A full counter may still take one more write if writeback frees a slot in the same cycle.
    assign haz_rd = rd_wr && (pc_q[rd_sel] == 2'd3) && !wb_hit_rd;

    assign stall = id_valid && !flush && (haz_rs || haz_rt || haz_rd);
    assign issue = id_valid && !flush && !stall;

    assign inc_vec = (issue && rd_wr) ? (8'b1 << rd_sel) : 8'h00;
    assign dec_vec = wb_valid ? (8'b1 << wb_sel) : 8'h00;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            pc_d[n] = pc_q[n];
            busy[n] = (pc_q[n] != 2'd0);
            if (inc_vec[n] && !dec_vec[n]) begin
                pc_d[n] = pc_q[n] + 2'd1;
            end else if (dec_vec[n] && !inc_vec[n] && (pc_q[n] != 2'd0)) begin
                pc_d[n] = pc_q[n] - 2'd1;
            end
        end
        sb_err_d    = sb_err_q || (wb_valid && (pc_q[wb_sel] == 2'd0));
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 8'hff)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 8; n++) begin
                pc_q[n] <= 2'd0;
            end
            stall_cnt_q <= 8'h00;
            sb_err_q    <= 1'b0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                pc_q[n] <= pc_d[n];
            end
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: directed scenarios then random traffic against a counter-array model.
module tb_decode_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, rs_used, rt_used, rd_wr, flush, wb_valid;
    logic [2:0] rs_sel, rt_sel, rd_sel, wb_sel;
    logic       stall, issue, sb_err;
    logic [7:0] busy, stall_cnt;

    int passed = 0;
    int total  = 0;

    int m_pc [8];
    int m_cnt;
    bit m_err;

    always #5 clk = ~clk;

    decode_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs_sel(rs_sel), .rs_used(rs_used), .rt_sel(rt_sel), .rt_used(rt_used),
        .rd_sel(rd_sel), .rd_wr(rd_wr), .flush(flush),
        .wb_valid(wb_valid), .wb_sel(wb_sel),
        .stall(stall), .issue(issue), .busy(busy),
        .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit src_haz(input bit used, input int r);
        bit h;
        h = used && (m_pc[r] > 0);
`ifdef FORWARD_WB_EN
        if (wb_valid && (int'(wb_sel) == r) && (m_pc[r] == 1)) h = 0;
`endif
        return h;
    endfunction

    function automatic bit m_stall();
        bit waw;
        waw = rd_wr && (m_pc[rd_sel] == 3) && !(wb_valid && wb_sel == rd_sel);
        return id_valid && !flush && (src_haz(rs_used, rs_sel) || src_haz(rt_used, rt_sel) || waw);
    endfunction

    function automatic logic [7:0] m_busy();
        logic [7:0] b;
        for (int n = 0; n < 8; n++) b[n] = (m_pc[n] > 0);
        return b;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < 8; n++) m_pc[n] = 0;
        m_cnt = 0;
        m_err = 0;
    endtask

    task automatic idle_in();
        id_valid = 0; rs_used = 0; rt_used = 0; rd_wr = 0; flush = 0; wb_valid = 0;
        rs_sel = 0; rt_sel = 0; rd_sel = 0; wb_sel = 0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit es, ei;
        #1;
        es = m_stall();
        ei = id_valid && !flush && !es;
        chk("stall", {7'b0, stall}, {7'b0, es});
        chk("issue", {7'b0, issue}, {7'b0, ei});
        if (wb_valid && m_pc[wb_sel] == 0) m_err = 1;
        if (es) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        if (!(ei && rd_wr && wb_valid && wb_sel == rd_sel)) begin
            if (ei && rd_wr) m_pc[rd_sel] = m_pc[rd_sel] + 1;
            if (wb_valid && m_pc[wb_sel] > 0) m_pc[wb_sel] = m_pc[wb_sel] - 1;
        end
        @(posedge clk);
        #1;
        chk("busy", busy, m_busy());
        chk("stall_cnt", stall_cnt, 8'(m_cnt));
        chk("sb_err", {7'b0, sb_err}, {7'b0, m_err});
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        clear_model();
        id_valid = 1;
        #12;
        chk("rst_busy", busy, 8'h00);
        chk("rst_cnt", stall_cnt, 8'h00);
        chk("rst_err", {7'b0, sb_err}, 8'h00);
        chk("rst_stall", {7'b0, stall}, 8'h00);
        chk("rst_issue", {7'b0, issue}, 8'h01);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // RAW on R2
        idle_in(); id_valid = 1; rd_sel = 2; rd_wr = 1;
        cycle();
        chk("raw_busy", busy, 8'h04);
        idle_in(); id_valid = 1; rs_sel = 2; rs_used = 1;
        #1; chk("raw_stall", {7'b0, stall}, 8'h01);
        cycle();
        wb_valid = 1; wb_sel = 2;
`ifdef FORWARD_WB_EN
        #1; chk("raw_fwd_stall", {7'b0, stall}, 8'h00);
        cycle();
`else
        #1; chk("raw_wb_stall", {7'b0, stall}, 8'h01);
        cycle();
        wb_valid = 0;
        #1; chk("raw_next_stall", {7'b0, stall}, 8'h00);
        cycle();
`endif

        // WAW limit on R5
        idle_in(); id_valid = 1; rd_sel = 5; rd_wr = 1;
        for (int i = 0; i < 3; i++) cycle();
        #1; chk("waw_stall", {7'b0, stall}, 8'h01);
        wb_valid = 1; wb_sel = 5;
        #1; chk("waw_wb_issue", {7'b0, issue}, 8'h01);
        cycle();
        wb_valid = 0;
        #1; chk("waw_still_full", {7'b0, stall}, 8'h01);
        cycle();

        // Simultaneous issue and writeback on R1
        idle_in(); id_valid = 1; rd_sel = 1; rd_wr = 1;
        cycle();
        wb_valid = 1; wb_sel = 1;
        cycle();
        chk("simul_busy1", {7'b0, busy[1]}, 8'h01);
        idle_in(); wb_valid = 1; wb_sel = 1;
        cycle();
        chk("simul_drain", {7'b0, busy[1]}, 8'h00);

        // Flush with an rs hazard on R5
        idle_in(); id_valid = 1; flush = 1; rs_sel = 5; rs_used = 1; rd_sel = 3; rd_wr = 1;
        #1;
        chk("flush_stall", {7'b0, stall}, 8'h00);
        chk("flush_issue", {7'b0, issue}, 8'h00);
        cycle();
        chk("flush_busy", busy, 8'h20);

        // Underflow on R7
        idle_in(); wb_valid = 1; wb_sel = 7;
        cycle();
        chk("uf_err", {7'b0, sb_err}, 8'h01);
        chk("uf_busy7", {7'b0, busy[7]}, 8'h00);
        idle_in();
        cycle();
        chk("uf_sticky", {7'b0, sb_err}, 8'h01);

        // Saturation: R5 stays busy, so reading it stalls every cycle
        idle_in(); id_valid = 1; rs_sel = 5; rs_used = 1;
        for (int i = 0; i < 300; i++) cycle();
        chk("sat_cnt", stall_cnt, 8'd255);

        // Mid-cycle asynchronous reset with R3 holding two pending writes
        idle_in(); id_valid = 1; rd_sel = 3; rd_wr = 1;
        cycle();
        cycle();
        idle_in();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 8'h00);
        chk("arst_cnt", stall_cnt, 8'h00);
        chk("arst_err", {7'b0, sb_err}, 8'h00);
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 600; i++) begin
            id_valid = ($urandom_range(3) != 0);
            rs_sel   = 3'($urandom_range(7));
            rt_sel   = 3'($urandom_range(7));
            rd_sel   = 3'($urandom_range(7));
            wb_sel   = 3'($urandom_range(7));
            rs_used  = 1'($urandom_range(1));
            rt_used  = 1'($urandom_range(1));
            rd_wr    = ($urandom_range(2) != 0);
            flush    = ($urandom_range(7) == 0);
            wb_valid = 1'($urandom_range(1));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
